// File: rtl/ie_defs.sv
// Shared definitions for the 6502 instruction fetch unit: FSM states and
// the opcode length table.
package ie_defs;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    WAIT_PC,
    FETCH,
    OPC,
    LO,
    HI,
    VALID
  } state_e;

  // Total instruction length in bytes (opcode included). The low nibble
  // selects the opcode column and the high nibble picks out the exceptions.
  // Undefined opcodes are treated as single-byte.
  function automatic logic [1:0] op_len(input logic [DATA_W-1:0] op);
    logic [3:0] hi_n;
    logic [3:0] lo_n;
    hi_n   = op[7:4];
    lo_n   = op[3:0];
    op_len = 2'd1;
    case (lo_n)
      4'h1, 4'h5, 4'h6: op_len = 2'd2;
      4'h9: begin
        if (hi_n[0])           op_len = 2'd3;
        else if (hi_n != 4'h8) op_len = 2'd2;
      end
      4'hD: op_len = 2'd3;
      4'h0: begin
        // Odd rows are the relative branches; 20 is JSR.
        if (hi_n[0])                        op_len = 2'd2;
        else if (hi_n == 4'h2)              op_len = 2'd3;
        else if (hi_n inside {4'hA, 4'hC, 4'hE}) op_len = 2'd2;
      end
      4'h2: if (hi_n == 4'hA) op_len = 2'd2;
      4'h4: if (hi_n inside {4'h2, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE}) op_len = 2'd2;
      4'hC: if (hi_n inside {4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE}) op_len = 2'd3;
      4'hE: if (hi_n != 4'h9) op_len = 2'd3;
      default: op_len = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/op_length_rom.sv
// Combinational opcode-to-length lookup.
module op_length_rom
  import ie_defs::*;
(
  input  logic [DATA_W-1:0] opcode_i,
  output logic [1:0]        len_o
);

  assign len_o = op_len(opcode_i);

endmodule

// File: rtl/inst_fetch.sv
// 6502 instruction fetch: reads opcode and operand bytes from a byte-wide
// memory with one-cycle read latency and presents whole instructions to decode.
module inst_fetch
  import ie_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              decode_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] opcode,
  output logic [15:0]       operand,
  output logic [1:0]        inst_len,
  output logic [ADDR_W-1:0] pc_out
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   opcode_q, opcode_d;
  logic [15:0]         operand_q, operand_d;
  logic [1:0]          len_q, len_d;
  logic [1:0]          rom_len;

  op_length_rom u_op_length_rom (
    .opcode_i (mem_rdata),
    .len_o    (rom_len)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_PC;
      pc_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    len_d      = len_q;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    inst_valid = 1'b0;

    unique case (state_q)
      WAIT_PC: state_d = WAIT_PC;
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        state_d  = OPC;
      end
      OPC: begin
        opcode_d  = mem_rdata;
        operand_d = '0;
        len_d     = rom_len;
        if (rom_len == 2'd1) begin
          state_d = VALID;
        end else begin
          mem_rd   = 1'b1;
          mem_addr = pc_q + 16'd1;
          state_d  = LO;
        end
      end
      LO: begin
        operand_d[7:0] = mem_rdata;
        if (len_q == 2'd3) begin
          mem_rd   = 1'b1;
          mem_addr = pc_q + 16'd2;
          state_d  = HI;
        end else begin
          state_d = VALID;
        end
      end
      HI: begin
        operand_d[15:8] = mem_rdata;
        state_d         = VALID;
      end
      VALID: begin
        inst_valid = 1'b1;
        if (decode_ready) begin
          pc_d    = pc_q + 16'(len_q);
          state_d = FETCH;
        end
      end
      default: state_d = WAIT_PC;
    endcase

    // A redirect squashes both the pending read and any presented
    // instruction, so decode never sees a transfer in the redirect cycle.
    if (pc_load) begin
      pc_d       = pc_in;
      state_d    = FETCH;
      mem_rd     = 1'b0;
      mem_addr   = '0;
      inst_valid = 1'b0;
    end

    if (rst) begin
      mem_rd     = 1'b0;
      mem_addr   = '0;
      inst_valid = 1'b0;
    end
  end

  assign opcode   = opcode_q;
  assign operand  = operand_q;
  assign inst_len = len_q;
  assign pc_out   = pc_q;

endmodule
